imm_encoder: RTL

- Inverse of the core's immediate decode path. Takes instruction fields plus a full 32-bit immediate and a format select, range-checks the immediate, and packs the 32-bit RV32I instruction word.
- Two-stage valid/ready pipeline.
- Used by the bootloader/BIST instruction patcher and as the round-trip partner of the immediate decoder in verification.

---
 rtl/riscv_imm_pkg.sv | 31 +++
 rtl/imm_pack_check.sv | 66 ++++++
 rtl/imm_encoder.sv | 115 +++++++++++
 3 files changed

// File: rtl/riscv_imm_pkg.sv
// rtl/riscv_imm_pkg.sv - RV32I immediate format selects, func3 codes and field positions
package riscv_imm_pkg;

    localparam int XLEN = 32;

    typedef enum logic [1:0] {
        IMM_SEL_I = 2'd0,
        IMM_SEL_S = 2'd1,
        IMM_SEL_B = 2'd2,
        IMM_SEL_U = 2'd3
    } imm_sel_e;

    localparam logic [2:0] SLLI_FUNC3  = 3'b001;
    localparam logic [2:0] SRI_FUNC3   = 3'b101;
    localparam logic [2:0] SLTIU_FUNC3 = 3'b011;

    localparam int OPCODE_LSB = 0;
    localparam int RD_LSB     = 7;
    localparam int FUNC3_LSB  = 12;
    localparam int RS1_LSB    = 15;
    localparam int RS2_LSB    = 20;
    localparam int FUNC7_LSB  = 25;

    // True when v[31:msb] are all equal, i.e. v is a sign extension of v[msb:0].
    function automatic logic sext_fits(input logic [XLEN-1:0] v, input int msb);
        logic [XLEN-1:0] hi;
        hi = $unsigned($signed(v) >>> msb);
        return (hi == '0) || (hi == '1);
    endfunction

endpackage

// File: rtl/imm_pack_check.sv
// rtl/imm_pack_check.sv - combinational RV32I word packer with immediate range check
module imm_pack_check
    import riscv_imm_pkg::*;
(
    input  logic [1:0]      i_imm_sel,
    input  logic [6:0]      i_opcode,
    input  logic [4:0]      i_rd,
    input  logic [4:0]      i_rs1,
    input  logic [4:0]      i_rs2,
    input  logic [2:0]      i_func3,
    input  logic [6:0]      i_func7,
    input  logic [XLEN-1:0] i_imm,
    output logic [XLEN-1:0] o_instr,
    output logic            o_err
);

    logic w_shift;

    assign w_shift = (i_imm_sel == IMM_SEL_I) && i_opcode[4] &&
                     ((i_func3 == SLLI_FUNC3) || (i_func3 == SRI_FUNC3));

    always_comb begin
        o_instr = '0;
        o_err   = 1'b0;
        o_instr[OPCODE_LSB +: 7] = i_opcode;
        case (imm_sel_e'(i_imm_sel))
            IMM_SEL_I: begin
                o_instr[RD_LSB +: 5]    = i_rd;
                o_instr[FUNC3_LSB +: 3] = i_func3;
                o_instr[RS1_LSB +: 5]   = i_rs1;
                if (w_shift) begin
                    o_instr[RS2_LSB +: 5]   = i_imm[4:0];
                    o_instr[FUNC7_LSB +: 7] = i_func7;
                    o_err = |i_imm[XLEN-1:5];
                end else begin
                    o_instr[31:20] = i_imm[11:0];
                    o_err = !sext_fits(i_imm, 11);
                end
            end
            IMM_SEL_S: begin
                o_instr[11:7]           = i_imm[4:0];
                o_instr[FUNC3_LSB +: 3] = i_func3;
                o_instr[RS1_LSB +: 5]   = i_rs1;
                o_instr[RS2_LSB +: 5]   = i_rs2;
                o_instr[31:25]          = i_imm[11:5];
                o_err = !sext_fits(i_imm, 11);
            end
            IMM_SEL_B: begin
                o_instr[7]              = i_imm[11];
                o_instr[11:8]           = i_imm[4:1];
                o_instr[FUNC3_LSB +: 3] = i_func3;
                o_instr[RS1_LSB +: 5]   = i_rs1;
                o_instr[RS2_LSB +: 5]   = i_rs2;
                o_instr[30:25]          = i_imm[10:5];
                o_instr[31]             = i_imm[12];
                o_err = !sext_fits(i_imm, 12) || i_imm[0];
            end
            default: begin
                o_instr[RD_LSB +: 5] = i_rd;
                o_instr[31:12]       = i_imm[31:12];
                o_err = |i_imm[11:0];
            end
        endcase
    end

endmodule

// File: rtl/imm_encoder.sv
// rtl/imm_encoder.sv - two-stage valid/ready RV32I instruction encoder with error counter
module imm_encoder
    import riscv_imm_pkg::*;
#(
    parameter int N         = 32,
    parameter int ERR_CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [1:0]           imm_sel,
    input  logic [6:0]           opcode,
    input  logic [4:0]           rd,
    input  logic [4:0]           rs1,
    input  logic [4:0]           rs2,
    input  logic [2:0]           func3,
    input  logic [6:0]           func7,
    input  logic [N-1:0]         imm,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [N-1:0]         instr,
    output logic                 err,
    output logic                 err_seen,
    input  logic                 clr_err,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    logic [N-1:0]         w_instr;
    logic                 w_err;
    logic                 w_a_ready;
    logic                 w_b_ready;
    logic                 w_err_evt;

    logic                 r_a_valid;
    logic [N-1:0]         r_a_instr;
    logic                 r_a_err;
    logic                 r_b_valid;
    logic [N-1:0]         r_b_instr;
    logic                 r_b_err;
    logic                 r_err_seen;
    logic [ERR_CNT_W-1:0] r_err_cnt;

    imm_pack_check u_pack (
        .i_imm_sel (imm_sel),
        .i_opcode  (opcode),
        .i_rd      (rd),
        .i_rs1     (rs1),
        .i_rs2     (rs2),
        .i_func3   (func3),
        .i_func7   (func7),
        .i_imm     (imm),
        .o_instr   (w_instr),
        .o_err     (w_err)
    );

    // Ready ripples back combinationally so a full pipe still moves one word per cycle.
    assign w_b_ready = !r_b_valid || out_ready;
    assign w_a_ready = !r_a_valid || w_b_ready;
    assign in_ready  = w_a_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a_valid <= 1'b0;
            r_a_instr <= '0;
            r_a_err   <= 1'b0;
        end else if (w_a_ready) begin
            r_a_valid <= in_valid;
            if (in_valid) begin
                r_a_instr <= w_instr;
                r_a_err   <= w_err;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_b_valid <= 1'b0;
            r_b_instr <= '0;
            r_b_err   <= 1'b0;
        end else if (w_b_ready) begin
            r_b_valid <= r_a_valid;
            if (r_a_valid) begin
                r_b_instr <= r_a_instr;
                r_b_err   <= r_a_err;
            end
        end
    end

    assign w_err_evt = r_b_valid && out_ready && r_b_err;

    // An erroneous handoff in the same cycle as clr_err leaves a count of one.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_err_seen <= 1'b0;
            r_err_cnt  <= '0;
        end else if (w_err_evt) begin
            r_err_seen <= 1'b1;
            if (clr_err)
                r_err_cnt <= ERR_CNT_W'(1);
            else if (r_err_cnt != '1)
                r_err_cnt <= r_err_cnt + 1'b1;
        end else if (clr_err) begin
            r_err_seen <= 1'b0;
            r_err_cnt  <= '0;
        end
    end

    assign out_valid = r_b_valid;
    assign instr     = r_b_instr;
    assign err       = r_b_err;
    assign err_seen  = r_err_seen;
    assign err_cnt   = r_err_cnt;

endmodule
